// File: rtl/matmul_loader.sv
// matmul_loader
// Streaming front end for the matrix multiplier. Elements arrive one per
// accepted valid/ready beat, row-major, all of A (M x N) followed by all of
// B (N x P). Each element lands in its own register slot, and the slots are
// wired straight out as flat buses. Once B is complete the loader stops
// accepting input and holds both operands with mats_valid high until the
// consumer pulses mats_ack. It then re-arms and loads A again.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_data     signed element, row-major, A first then B
//   in_valid    in_data is valid this cycle
//   in_ready    loader accepts an element this cycle (state decode only)
//   A_flat      A(r,c) at [(r*N+c)*DATAWIDTH +: DATAWIDTH]
//   B_flat      B(r,c) at [(r*P+c)*DATAWIDTH +: DATAWIDTH]
//   mats_valid  both operands complete and stable (state decode only)
//   mats_ack    consumer has taken the operands; only honoured while full
//   loading_b   loader is currently filling B (state decode only)
module matmul_loader #(
  parameter int DATAWIDTH = 8,
  parameter int M         = 2,
  parameter int N         = 2,
  parameter int P         = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DATAWIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [M*N*DATAWIDTH-1:0]    A_flat,
  output logic [N*P*DATAWIDTH-1:0]    B_flat,
  output logic                        mats_valid,
  input  logic                        mats_ack,
  output logic                        loading_b
);

  localparam int NA   = M * N;
  localparam int NB   = N * P;
  localparam int MAXE = (NA > NB) ? NA : NB;
  localparam int IDXW = (MAXE > 1) ? $clog2(MAXE) : 1;

  // A zero-sized operand has no meaningful load sequence, so refuse to build.
  generate
    if (M < 1 || N < 1 || P < 1) begin : g_bad_dims
      $error("matmul_loader: M, N and P must all be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [IDXW-1:0] idx_reg, idx_next;
  logic            a_we, b_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LOAD_A;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // The handshake outputs depend only on state_reg. in_valid and mats_ack
  // affect only the next state and the write enables.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    in_ready   = 1'b0;
    mats_valid = 1'b0;
    loading_b  = 1'b0;
    a_we       = 1'b0;
    b_we       = 1'b0;
    case (state_reg)
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_we = 1'b1;
          if (idx_reg == IDXW'(NA - 1)) begin
            idx_next   = '0;
            state_next = LOAD_B;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      LOAD_B: begin
        in_ready  = 1'b1;
        loading_b = 1'b1;
        if (in_valid) begin
          b_we = 1'b1;
          if (idx_reg == IDXW'(NB - 1)) begin
            idx_next   = '0;
            state_next = FULL;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      FULL: begin
        mats_valid = 1'b1;
        if (mats_ack) begin
          state_next = LOAD_A;
        end
      end
      default: begin
        state_next = LOAD_A;
        idx_next   = '0;
      end
    endcase
  end

  // One register per element. Slots are not cleared on re-arm, so during a
  // reload the buses carry a mix of new and previous elements.
  genvar gi;
  generate
    for (gi = 0; gi < NA; gi++) begin : g_a_slot
      logic [DATAWIDTH-1:0] slot_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          slot_reg <= '0;
        end else if (a_we && idx_reg == IDXW'(gi)) begin
          slot_reg <= in_data;
        end
      end
      assign A_flat[gi*DATAWIDTH +: DATAWIDTH] = slot_reg;
    end

    for (gi = 0; gi < NB; gi++) begin : g_b_slot
      logic [DATAWIDTH-1:0] slot_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          slot_reg <= '0;
        end else if (b_we && idx_reg == IDXW'(gi)) begin
          slot_reg <= in_data;
        end
      end
      assign B_flat[gi*DATAWIDTH +: DATAWIDTH] = slot_reg;
    end
  endgenerate

endmodule

// File: tb/tb_matmul_loader.sv
// tb_matmul_loader
// Scoreboard bench for matmul_loader with M=N=P=2 and DATAWIDTH=8. The bench
// keeps a model of the A/B slot contents. When the last element of a pair is
// driven, the expected operands are pushed to a queue. When mats_valid is
// seen, the queue is popped and the result is compared.
module tb_matmul_loader;

  localparam int DW = 8;
  localparam int M  = 2;
  localparam int N  = 2;
  localparam int P  = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [DW-1:0]     in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [M*N*DW-1:0]        A_flat;
  logic [N*P*DW-1:0]        B_flat;
  logic                     mats_valid;
  logic                     mats_ack;
  logic                     loading_b;

  matmul_loader #(.DATAWIDTH(DW), .M(M), .N(N), .P(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A_flat    (A_flat),
    .B_flat    (B_flat),
    .mats_valid(mats_valid),
    .mats_ack  (mats_ack),
    .loading_b (loading_b)
  );

  always #5 clk = ~clk;

  int          n_vectors     = 0;
  int          n_miscompares = 0;
  int          n_pairs       = 0;
  int          pos;
  logic [31:0] exp_a, exp_b;
  logic [63:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one element and check the outputs the cycle after its accept edge.
  // Optionally add an idle cycle with in_valid low, carrying garbage data and
  // an optional stray ack.
  task automatic send(input logic [7:0] v, input bit idle_after, input bit ack_idle);
    int p;
    p        = pos;
    in_valid = 1'b1;
    in_data  = v;
    tick();
    if (p < 4) exp_a[p*8 +: 8] = v;
    else       exp_b[(p-4)*8 +: 8] = v;
    if (p == 7) sb_q.push_back({exp_a, exp_b});
    check("a_elem", A_flat, exp_a);
    check("b_elem", B_flat, exp_b);
    check("loading_b", loading_b, (p >= 3 && p < 7));
    check("mats_valid", mats_valid, (p == 7));
    check("in_ready", in_ready, (p != 7));
    pos      = (p == 7) ? 0 : p + 1;
    in_valid = 1'b0;
    in_data  = 8'hAA;
    if (idle_after) begin
      mats_ack = ack_idle;
      tick();
      mats_ack = 1'b0;
      check("stall_a", A_flat, exp_a);
      check("stall_b", B_flat, exp_b);
      check("stall_valid", mats_valid, (p == 7));
    end
  endtask

  task automatic score();
    logic [63:0] e;
    for (int i = 0; i < 20 && !mats_valid; i++) tick();
    check("full_timeout", mats_valid, 1'b1);
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check("sb_a", A_flat, e[63:32]);
      check("sb_b", B_flat, e[31:0]);
      $display("pair %0d: A_flat=%h B_flat=%h", n_pairs, A_flat, B_flat);
      n_pairs++;
    end
  endtask

  task automatic do_ack();
    mats_ack = 1'b1;
    tick();
    mats_ack = 1'b0;
    check("ack_valid", mats_valid, 1'b0);
    check("ack_ready", in_ready, 1'b1);
    check("ack_keep_a", A_flat, exp_a);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    mats_ack = 1'b0;
    pos      = 0;
    exp_a    = '0;
    exp_b    = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", in_ready, 1'b1);
    check("rst_valid", mats_valid, 1'b0);
    check("rst_a", A_flat, 32'h0);
    check("rst_b", B_flat, 32'h0);
    check("rst_loading_b", loading_b, 1'b0);

    // Full load, back to back, 1..8.
    for (int i = 0; i < 8; i++) send(8'(i + 1), 1'b0, 1'b0);
    score();
    check("full_a_const", A_flat, 32'h04030201);
    check("full_b_const", B_flat, 32'h08070605);

    // Hold in FULL while valid data is offered and no ack is given.
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_a", A_flat, 32'h04030201);
      check("hold_b", B_flat, 32'h08070605);
      check("hold_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    do_ack();

    for (int i = 0; i < 8; i++) send(8'(i + 9), 1'b0, 1'b0);
    score();
    check("reload_a_const", A_flat, 32'h0C0B0A09);
    check("reload_b_const", B_flat, 32'h100F0E0D);
    do_ack();

    // Alternating valid with a stray ack during LOAD_A.
    for (int i = 0; i < 8; i++) send(8'(i + 1), 1'b1, (i < 3));
    score();
    check("stall_a_const", A_flat, 32'h04030201);
    check("stall_b_const", B_flat, 32'h08070605);
    do_ack();

    // Signed passthrough.
    send(8'hFF, 1'b0, 1'b0);
    send(8'h80, 1'b0, 1'b0);
    send(8'h7F, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(8'(8'hF0 + i), 1'b0, 1'b0);
    score();
    check("signed_s0", A_flat[7:0],   8'hFF);
    check("signed_s1", A_flat[15:8],  8'h80);
    check("signed_s2", A_flat[23:16], 8'h7F);
    check("signed_s3", A_flat[31:24], 8'h00);
    do_ack();

    // Reset after 6 accepts. Reset wins over a simultaneous accept.
    for (int i = 0; i < 6; i++) send(8'(8'h21 + i), 1'b0, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    pos      = 0;
    exp_a    = '0;
    exp_b    = '0;
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_valid", mats_valid, 1'b0);
    check("mid_rst_a", A_flat, 32'h0);
    check("mid_rst_b", B_flat, 32'h0);
    check("mid_rst_loading_b", loading_b, 1'b0);
    for (int i = 0; i < 8; i++) send(8'(8'h31 + i), 1'b0, 1'b0);
    score();
    check("post_rst_a", A_flat, 32'h34333231);
    check("post_rst_b", B_flat, 32'h38373635);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
